// File: rtl/warp_sched_pkg.sv
// Shared scheduler definitions: issue-policy encodings and age-counter saturation helper.
package warp_sched_pkg;

  typedef enum logic {
    SCHED_RR  = 1'b0,
    SCHED_GTO = 1'b1
  } sched_mode_e;

  // Largest value an age counter of the given width can hold before it saturates.
  function automatic int unsigned age_sat_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/warp_prio_pick.sv
// Rotating search from start_i over a candidate mask: first match, or oldest
// candidate when age_en_i is set (ties go to the first hit after start_i).
module warp_prio_pick #(
  parameter int unsigned W        = 16,
  parameter int unsigned ID_BITS  = $clog2(W),
  parameter int unsigned AGE_BITS = 4
) (
  input  logic [W-1:0]               cand_i,
  input  logic [W-1:0][AGE_BITS-1:0] age_i,
  input  logic [ID_BITS-1:0]         start_i,
  input  logic                       age_en_i,
  output logic                       found_o,
  output logic [ID_BITS-1:0]         idx_o
);

  logic [ID_BITS-1:0]  idx;
  logic [AGE_BITS-1:0] best;

  always_comb begin
    found_o = 1'b0;
    idx_o   = start_i;
    idx     = start_i;
    best    = '0;
    // Strict '>' keeps the earliest index in scan order on equal ages.
    for (int unsigned k = 0; k < W; k++) begin
      idx = start_i + ID_BITS'(k);
      if (cand_i[idx] && (!found_o || (age_en_i && (age_i[idx] > best)))) begin
        found_o = 1'b1;
        idx_o   = idx;
        best    = age_i[idx];
      end
    end
  end

endmodule

// File: rtl/warp_sched_gto.sv
// Warp issue scheduler: loose round-robin or greedy-then-oldest with a starvation
// override, presenting one registered warp id per cycle under valid/ready flow control.
module warp_sched_gto
  import warp_sched_pkg::*;
#(
  parameter int unsigned W          = 16,
  parameter int unsigned ID_BITS    = $clog2(W),
  parameter int unsigned AGE_BITS   = 4,
  parameter int unsigned STARVE_LIM = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [W-1:0]       ready_vec,
  input  logic               issue_ready,
  output logic               issue_valid,
  output logic [ID_BITS-1:0] issue_id
);

  localparam logic [AGE_BITS-1:0] AGE_MAX = AGE_BITS'(age_sat_max(AGE_BITS));
  localparam logic [AGE_BITS-1:0] STARVE  = AGE_BITS'(STARVE_LIM);

  logic                       issue_valid_q;
  logic [ID_BITS-1:0]         issue_id_q;
  logic                       last_valid_q;
  logic [ID_BITS-1:0]         last_id_q;
  logic [ID_BITS-1:0]         ptr_q;
  logic [W-1:0][AGE_BITS-1:0] age_q;

  sched_mode_e        mode_e;
  logic [W-1:0]       starve_mask;
  logic [W-1:0]       pick_mask;
  logic               pick_age_en;
  logic               use_greedy;
  logic               pick_found;
  logic [ID_BITS-1:0] pick_idx;
  logic               slot_free;
  logic               sel_ok;
  logic [ID_BITS-1:0] sel_id;
  logic               load;

  assign mode_e    = sched_mode_e'(mode);
  assign slot_free = !issue_valid_q || issue_ready;

  always_comb begin
    starve_mask = '0;
    for (int unsigned w = 0; w < W; w++) begin
      starve_mask[w] = ready_vec[w] && (age_q[w] >= STARVE);
    end
  end

  // One shared picker: starving set (oldest), else greedy hold, else oldest ready;
  // RR reuses it as a plain rotating first-match over ready warps.
  always_comb begin
    pick_mask   = ready_vec;
    pick_age_en = 1'b0;
    use_greedy  = 1'b0;
    if (mode_e == SCHED_GTO) begin
      pick_age_en = 1'b1;
      if (|starve_mask) begin
        pick_mask = starve_mask;
      end else if (last_valid_q && ready_vec[last_id_q]) begin
        use_greedy = 1'b1;
      end
    end
  end

  warp_prio_pick #(
    .W       (W),
    .ID_BITS (ID_BITS),
    .AGE_BITS(AGE_BITS)
  ) u_pick (
    .cand_i  (pick_mask),
    .age_i   (age_q),
    .start_i (ptr_q),
    .age_en_i(pick_age_en),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign sel_ok = use_greedy || pick_found;
  assign sel_id = use_greedy ? last_id_q : pick_idx;
  assign load   = slot_free && sel_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid_q <= 1'b0;
      issue_id_q    <= '0;
      last_valid_q  <= 1'b0;
      last_id_q     <= '0;
      ptr_q         <= '0;
      age_q         <= '0;
    end else begin
      if (slot_free) begin
        issue_valid_q <= sel_ok;
        if (sel_ok) begin
          issue_id_q   <= sel_id;
          last_valid_q <= 1'b1;
          last_id_q    <= sel_id;
          ptr_q        <= sel_id + ID_BITS'(1);
        end
      end
      for (int unsigned w = 0; w < W; w++) begin
        if (load && (sel_id == ID_BITS'(w))) begin
          age_q[w] <= '0;
        end else if (ready_vec[w]) begin
          if (age_q[w] != AGE_MAX) age_q[w] <= age_q[w] + AGE_BITS'(1);
        end else begin
          age_q[w] <= '0;
        end
      end
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_id    = issue_id_q;

endmodule

// File: tb/tb_warp_sched_gto.sv
// Bench for warp_sched_gto (W=8, AGE_BITS=4, STARVE_LIM=6): directed scenarios plus
// randomized traffic against a behavioural policy model.
module tb_warp_sched_gto;

  localparam int NW  = 8;
  localparam int LIM = 6;
  localparam int AMX = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] ready_vec = '0;
  logic       issue_ready = 1'b0;
  logic       issue_valid;
  logic [2:0] issue_id;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int m_age [NW];
  int m_last_id;
  bit m_last_valid;
  int m_ptr;
  bit m_valid;
  int m_id;

  warp_sched_gto #(
    .W         (8),
    .AGE_BITS  (4),
    .STARVE_LIM(6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .ready_vec  (ready_vec),
    .issue_ready(issue_ready),
    .issue_valid(issue_valid),
    .issue_id   (issue_id)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int w = 0; w < NW; w++) m_age[w] = 0;
    m_last_id = 0; m_last_valid = 0; m_ptr = 0; m_valid = 0; m_id = 0;
  endtask

  function automatic int first_from_ptr(input bit [7:0] cand);
    for (int k = 0; k < NW; k++) begin
      if (cand[(m_ptr + k) % NW]) return (m_ptr + k) % NW;
    end
    return -1;
  endfunction

  function automatic int oldest_from_ptr(input bit [7:0] cand);
    int sel = -1;
    int best = -1;
    for (int k = 0; k < NW; k++) begin
      int i = (m_ptr + k) % NW;
      if (cand[i] && m_age[i] > best) begin sel = i; best = m_age[i]; end
    end
    return sel;
  endfunction

  // Applies one rising edge's worth of policy to the model using the current inputs.
  task automatic model_edge();
    int sel = -1;
    bit [7:0] starving = '0;
    bit loaded = 0;
    if (!m_valid || issue_ready) begin
      if (!mode) begin
        sel = first_from_ptr(ready_vec);
      end else begin
        for (int w = 0; w < NW; w++) starving[w] = ready_vec[w] && m_age[w] >= LIM;
        sel = oldest_from_ptr(starving);
        if (sel < 0 && m_last_valid && ready_vec[m_last_id]) sel = m_last_id;
        if (sel < 0) sel = oldest_from_ptr(ready_vec);
      end
      m_valid = (sel >= 0);
      if (sel >= 0) begin
        loaded = 1; m_id = sel; m_last_id = sel; m_last_valid = 1; m_ptr = (sel + 1) % NW;
      end
    end
    for (int w = 0; w < NW; w++) begin
      if (loaded && w == sel) m_age[w] = 0;
      else if (ready_vec[w]) m_age[w] = (m_age[w] < AMX) ? m_age[w] + 1 : AMX;
      else m_age[w] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (issue_valid !== 1'b0 || issue_id !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_async: got valid=%0b id=%0d, want valid=0 id=0", issue_valid, issue_id);
    end
    do_reset();
    #1;
    n_cmp++;
    if (issue_valid !== 1'b0 || issue_id !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_release: got valid=%0b id=%0d, want valid=0 id=0", issue_valid, issue_id);
    end
  endtask

  task automatic test_rr();
    int exp_id [6] = '{0, 2, 5, 7, 0, 2};
    do_reset();
    mode = 1'b0; ready_vec = 8'b1010_0101; issue_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (issue_valid !== 1'b1 || issue_id !== 3'(exp_id[i]) || m_id != exp_id[i]) begin
        n_bad++;
        $display("FAIL rr_seq[%0d]: got valid=%0b id=%0d, want valid=1 id=%0d", i, issue_valid, issue_id, exp_id[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b0; ready_vec = 8'b1010_0101; issue_ready = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (issue_valid !== 1'b1 || issue_id !== 3'd2) begin
      n_bad++;
      $display("FAIL bp_present: got valid=%0b id=%0d, want valid=1 id=2", issue_valid, issue_id);
    end
    issue_ready = 1'b0; ready_vec = 8'b1010_0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 1) mode = 1'b1;
      n_cmp++;
      if (issue_valid !== 1'b1 || issue_id !== 3'd2) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got valid=%0b id=%0d, want valid=1 id=2", i, issue_valid, issue_id);
      end
    end
    mode = 1'b0; issue_ready = 1'b1;
    tick();
    n_cmp++;
    if (issue_valid !== 1'b1 || issue_id !== 3'd5) begin
      n_bad++;
      $display("FAIL bp_after: got valid=%0b id=%0d, want valid=1 id=5", issue_valid, issue_id);
    end
  endtask

  task automatic test_gto_starve();
    int exp_id [8] = '{0, 0, 0, 0, 0, 0, 1, 2};
    do_reset();
    mode = 1'b1; ready_vec = 8'hFF; issue_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (issue_valid !== 1'b1 || issue_id !== 3'(exp_id[i]) || m_id != exp_id[i]) begin
        n_bad++;
        $display("FAIL gto_starve[%0d]: got valid=%0b id=%0d, want valid=1 id=%0d", i, issue_valid, issue_id, exp_id[i]);
      end
    end
  endtask

  task automatic test_gto_fallback();
    bit [7:0] pat [6] = '{8'h08, 8'h0A, 8'h0A, 8'h4A, 8'h4A, 8'h42};
    int exp_id [6] = '{3, 3, 3, 3, 3, 1};
    do_reset();
    mode = 1'b1; issue_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ready_vec = pat[i];
      tick();
      n_cmp++;
      if (issue_valid !== 1'b1 || issue_id !== 3'(exp_id[i])) begin
        n_bad++;
        $display("FAIL gto_fallback[%0d]: got valid=%0b id=%0d, want valid=1 id=%0d", i, issue_valid, issue_id, exp_id[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mode = 1'b0; ready_vec = 8'h20; issue_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (issue_valid !== 1'b1 || issue_id !== 3'd5) begin
        n_bad++;
        $display("FAIL b2b_rr[%0d]: got valid=%0b id=%0d, want valid=1 id=5", i, issue_valid, issue_id);
      end
    end
    ready_vec = 8'h00;
    tick();
    n_cmp++;
    if (issue_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_clear: got valid=%0b, want valid=0", issue_valid);
    end
  endtask

  task automatic test_mid_stall_reset();
    do_reset();
    mode = 1'b0; ready_vec = 8'h0E; issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (issue_valid !== 1'b0 || issue_id !== 3'd0) begin
      n_bad++;
      $display("FAIL stall_reset_out: got valid=%0b id=%0d, want valid=0 id=0", issue_valid, issue_id);
    end
    n_cmp++;
    if (dut.age_q !== '0) begin
      n_bad++;
      $display("FAIL stall_reset_age: got ages=%h, want 0", dut.age_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ready_vec = 8'h10; issue_ready = 1'b1;
    tick();
    n_cmp++;
    if (issue_valid !== 1'b1 || issue_id !== 3'd4) begin
      n_bad++;
      $display("FAIL stall_reset_resume: got valid=%0b id=%0d, want valid=1 id=4", issue_valid, issue_id);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 16 == 0) mode = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       ready_vec = 8'($urandom);
        1:       ready_vec = 8'($urandom & $urandom);
        2:       ready_vec = 8'($urandom | $urandom);
        default: ready_vec = 8'h01 << $urandom_range(0, 7);
      endcase
      issue_ready = ($urandom_range(0, 3) != 0);
      tick();
      n_cmp++;
      if (issue_valid !== m_valid || (m_valid && issue_id !== 3'(m_id))) begin
        n_bad++;
        $display("FAIL random[%0d]: got valid=%0b id=%0d, want valid=%0b id=%0d", i, issue_valid, issue_id, m_valid, m_id);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr();
    test_backpressure();
    test_gto_starve();
    test_gto_fallback();
    test_back_to_back();
    test_mid_stall_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/warp_sched_gto.md
WARP_SCHED_GTO -- requirements
Module: warp_sched_gto

Interface
REQ-001 SHALL have parameter W, default 16: number of warps, power of two, 2..64.
REQ-002 SHALL have parameter ID_BITS, default $clog2(W): warp id width.
REQ-003 SHALL have parameter AGE_BITS, default 4: per-warp age counter width.
REQ-004 SHALL have parameter STARVE_LIM, default 12: age at or above which a ready warp is starving; range 1..2^AGE_BITS-1.
REQ-005 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port mode, input, 1: 0 = loose round-robin (RR), 1 = greedy-then-oldest (GTO).
REQ-008 SHALL have port ready_vec, input, W: per-warp ready to issue.
REQ-009 SHALL have port issue_ready, input, 1: downstream dispatch accepts the presented warp.
REQ-010 SHALL have port issue_valid, output, 1: a warp id is presented.
REQ-011 SHALL have port issue_id, output, ID_BITS: presented warp id.

Function
REQ-012 SHALL present issue_valid/issue_id from registers only; output slot is free when !issue_valid || issue_ready.
REQ-013 SHALL, at an edge with a free slot, load the selected warp if any ready_vec bit is 1, else clear issue_valid; latency from ready_vec sample to issue_valid is 1 cycle.
REQ-014 SHALL hold issue_id and issue_valid unchanged while issue_valid && !issue_ready, irrespective of ready_vec or mode changes.
REQ-015 SHALL keep last_id/last_valid (last loaded warp) and rotating pointer ptr = (last_id+1) mod W, updated on every load; ptr wraps from W-1 to 0.
REQ-016 SHALL, in RR mode, select the first ready warp scanning ptr, ptr+1, ... modulo W.
REQ-017 SHALL, in GTO mode, select by priority: (a) starving warps (ready and age >= STARVE_LIM) -- maximum age; (b) else last_id if last_valid and ready_vec[last_id]; (c) else maximum age among ready warps.
REQ-018 SHALL break age ties by first index scanning from ptr modulo W.
REQ-019 SHALL maintain one age counter per warp: on load of that warp -> 0; else if ready_vec[w] -> saturating increment at 2^AGE_BITS-1; else -> 0.
REQ-020 SHALL update age counters every cycle in both modes, including stall cycles.
REQ-021 SHALL allow the just-accepted warp to be reloaded in the immediately following slot (back-to-back issue).
REQ-022 SHALL sample mode only at load edges; a change takes effect on the next selection.

Reset
REQ-023 SHALL, on rst_n low, immediately drive issue_valid=0, issue_id=0, last_valid=0, last_id=0, ptr=0, all ages=0, including mid-stall.
REQ-024 SHALL resume selection at the first rising clk edge after rst_n rises.

Structure
REQ-025 SHALL place mode encodings (SCHED_RR, SCHED_GTO) and age-saturation helper constants in shared package warp_sched_pkg.
REQ-026 SHALL implement rotating first-match / max-age search as sub-module warp_prio_pick (inputs: candidate mask, ages, start pointer; outputs: found, index).

Verification (W=8, AGE_BITS=4, STARVE_LIM=6)
REQ-027 SHALL cover reset: rst_n low -> issue_valid=0, issue_id=0 asynchronously, no clk edge needed.
REQ-028 SHALL cover RR: mode=0, ready_vec=8'b1010_0101, issue_ready=1 -> issue_id 0,2,5,7,0,2 on consecutive cycles.
REQ-029 SHALL cover backpressure: RR, id 2 presented, issue_ready=0 for 3 cycles, ready_vec[2] dropped -> id 2 held valid 3 cycles; after acceptance next id is 5.
REQ-030 SHALL cover GTO starvation: mode=1, ready_vec=8'hFF, issue_ready=1 from reset -> warp 0 issued 6 consecutive times, then warp 1, then warp 2.
REQ-031 SHALL cover GTO fallback: greedy warp 3 drops ready while warps 1 (age 4) and 6 (age 2) ready -> warp 1 issued next.
REQ-032 SHALL cover mid-stall reset: rst_n low during held grant -> outputs and ages cleared; after release, ready_vec=8'h10 -> issue_id=4 one cycle later.
